// File: rtl/plate_boarder_detect_pkg.sv
// rtl/plate_boarder_detect_pkg.sv - shared image geometry and plate box types/helpers
package plate_boarder_detect_pkg;

  // Image geometry shared with the other image-process blocks
  localparam logic [9:0] IMG_HDISP_DEF = 10'd640;
  localparam logic [9:0] IMG_VDISP_DEF = 10'd480;
  localparam logic [9:0] COORD_MAX     = 10'h3FF;

  typedef struct packed {
    logic [9:0] up;
    logic [9:0] down;
    logic [9:0] left;
    logic [9:0] right;
    logic       found;
  } plate_box_t;

  // Empty box: left starts at the top of the range so the first min() takes the row value
  localparam plate_box_t BOX_INIT = '{up: 10'd0, down: 10'd0, left: 10'h3FF,
                                      right: 10'd0, found: 1'b0};

  // Size and aspect check; widths carried in 11 bits, doubled height in 12
  function automatic logic box_ok(input plate_box_t b, input logic [9:0] min_w,
                                  input logic [9:0] min_h);
    logic [10:0] w;
    logic [10:0] h;
    logic [11:0] h2;
    w  = {1'b0, b.right} - {1'b0, b.left} + 11'd1;
    h  = {1'b0, b.down} - {1'b0, b.up} + 11'd1;
    h2 = {h, 1'b0};
    return b.found && (w >= {1'b0, min_w}) && (h >= {1'b0, min_h}) && ({1'b0, w} >= h2);
  endfunction

endpackage

// File: rtl/plate_row_stat.sv
// rtl/plate_row_stat.sv - per-row mask pixel count and first/last x tracker
module plate_row_stat
  import plate_boarder_detect_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pix_en,
  input  logic       pix_bit,
  input  logic [9:0] pix_x,
  input  logic       clear,
  output logic [9:0] row_cnt,
  output logic [9:0] row_first,
  output logic [9:0] row_last
);

  logic [9:0] cnt_q, cnt_d;
  logic [9:0] first_q, first_d;
  logic [9:0] last_q, last_d;

  // Count mask pixels (saturating), remember first and latest hit; clear wins
  always_comb begin
    cnt_d   = cnt_q;
    first_d = first_q;
    last_d  = last_q;
    if (clear) begin
      cnt_d   = '0;
      first_d = '0;
      last_d  = '0;
    end else if (pix_en && pix_bit) begin
      if (cnt_q != COORD_MAX) cnt_d = cnt_q + 10'd1;
      if (cnt_q == '0) first_d = pix_x;
      last_d = pix_x;
    end
  end

  // Row statistic registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      first_q <= '0;
      last_q  <= '0;
    end else begin
      cnt_q   <= cnt_d;
      first_q <= first_d;
      last_q  <= last_d;
    end
  end

  assign row_cnt   = cnt_q;
  assign row_first = first_q;
  assign row_last  = last_q;

endmodule

// File: rtl/plate_boarder_detect.sv
// rtl/plate_boarder_detect.sv - licence plate bounding box detector over a binary mask
module plate_boarder_detect
  import plate_boarder_detect_pkg::*;
#(
  parameter logic [9:0] IMG_HDISP  = IMG_HDISP_DEF,
  parameter logic [9:0] IMG_VDISP  = IMG_VDISP_DEF,
  parameter logic [9:0] ROW_THRESH = 10'd20,
  parameter logic [9:0] MIN_W      = 10'd40,
  parameter logic [9:0] MIN_H      = 10'd10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       per_frame_vsync,
  input  logic       per_frame_href,
  input  logic       per_frame_clken,
  input  logic       per_frame_bit,
  output logic [9:0] plate_boarder_up,
  output logic [9:0] plate_boarder_down,
  output logic [9:0] plate_boarder_left,
  output logic [9:0] plate_boarder_right,
  output logic       plate_exist_flag,
  output logic       plate_valid
);

  typedef enum logic [1:0] {ST_WAIT_FRAME, ST_ACTIVE, ST_LATCH} state_e;

  state_e     state_q, state_d;
  logic       vsync_q, vsync_d, href_q, href_d;
  logic [9:0] x_q, x_d, y_q, y_d;
  plate_box_t acc_q, acc_d;
  logic [9:0] up_q, up_d, down_q, down_d, left_q, left_d, right_q, right_d;
  logic       flag_q, flag_d, valid_q, valid_d;
  logic       vsync_rise, href_fall, pix_en, row_clear, row_commit;
  logic [9:0] row_cnt, row_first, row_last;

  plate_row_stat u_row_stat (
    .clk      (clk),
    .rst_n    (rst_n),
    .pix_en   (pix_en),
    .pix_bit  (per_frame_bit),
    .pix_x    (x_q),
    .clear    (row_clear),
    .row_cnt  (row_cnt),
    .row_first(row_first),
    .row_last (row_last)
  );

  // Sync edges, x/y counters, row commit, frame accumulation and latch FSM
  always_comb begin
    vsync_d    = per_frame_vsync;
    href_d     = per_frame_href;
    vsync_rise = per_frame_vsync & ~vsync_q;
    href_fall  = ~per_frame_href & href_q;
    x_d        = x_q;
    y_d        = y_q;
    state_d    = state_q;
    acc_d      = acc_q;
    up_d       = up_q;
    down_d     = down_q;
    left_d     = left_q;
    right_d    = right_q;
    flag_d     = flag_q;
    valid_d    = 1'b0;

    // Pixels past the active width are never counted; rows past the height never commit
    pix_en     = (state_q == ST_ACTIVE) && per_frame_href && per_frame_clken && (x_q < IMG_HDISP);
    row_commit = (state_q == ST_ACTIVE) && href_fall && (row_cnt >= ROW_THRESH) && (y_q < IMG_VDISP);
    row_clear  = href_fall || vsync_rise || (state_q != ST_ACTIVE);

    if (vsync_rise || href_fall) begin
      x_d = '0;
    end else if (per_frame_href && per_frame_clken && (x_q != COORD_MAX)) begin
      x_d = x_q + 10'd1;
    end
    if (vsync_rise) begin
      y_d = '0;
    end else if (href_fall && (y_q != COORD_MAX)) begin
      y_d = y_q + 10'd1;
    end

    unique case (state_q)
      ST_WAIT_FRAME: begin
        acc_d = BOX_INIT;
        if (vsync_rise) state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        // A commit coinciding with vsync_rise still lands in the frame being closed
        if (row_commit) begin
          if (!acc_q.found) acc_d.up = y_q;
          acc_d.down  = y_q;
          if (row_first < acc_q.left) acc_d.left = row_first;
          if (row_last > acc_q.right) acc_d.right = row_last;
          acc_d.found = 1'b1;
        end
        if (vsync_rise) state_d = ST_LATCH;
      end
      ST_LATCH: begin
        up_d    = acc_q.up;
        down_d  = acc_q.down;
        left_d  = acc_q.left;
        right_d = acc_q.right;
        flag_d  = box_ok(acc_q, MIN_W, MIN_H);
        valid_d = 1'b1;
        acc_d   = BOX_INIT;
        state_d = ST_ACTIVE;
      end
      default: state_d = ST_WAIT_FRAME;
    endcase
  end

  // State, counters, accumulators and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_WAIT_FRAME;
      vsync_q <= 1'b0;
      href_q  <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      acc_q   <= BOX_INIT;
      up_q    <= '0;
      down_q  <= '0;
      left_q  <= '0;
      right_q <= '0;
      flag_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      vsync_q <= vsync_d;
      href_q  <= href_d;
      x_q     <= x_d;
      y_q     <= y_d;
      acc_q   <= acc_d;
      up_q    <= up_d;
      down_q  <= down_d;
      left_q  <= left_d;
      right_q <= right_d;
      flag_q  <= flag_d;
      valid_q <= valid_d;
    end
  end

  assign plate_boarder_up    = up_q;
  assign plate_boarder_down  = down_q;
  assign plate_boarder_left  = left_q;
  assign plate_boarder_right = right_q;
  assign plate_exist_flag    = flag_q;
  assign plate_valid         = valid_q;

endmodule

// File: tb/tb_plate_boarder_detect.sv
// tb/tb_plate_boarder_detect.sv - self-checking bench for plate_boarder_detect
module tb_plate_boarder_detect;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       per_frame_vsync, per_frame_href, per_frame_clken, per_frame_bit;
  logic [9:0] plate_boarder_up, plate_boarder_down, plate_boarder_left, plate_boarder_right;
  logic       plate_exist_flag, plate_valid;

  int n_pass  = 0;
  int n_total = 0;
  bit line_bits [1024];

  always #5 clk = ~clk;

  plate_boarder_detect dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .per_frame_vsync    (per_frame_vsync),
    .per_frame_href     (per_frame_href),
    .per_frame_clken    (per_frame_clken),
    .per_frame_bit      (per_frame_bit),
    .plate_boarder_up   (plate_boarder_up),
    .plate_boarder_down (plate_boarder_down),
    .plate_boarder_left (plate_boarder_left),
    .plate_boarder_right(plate_boarder_right),
    .plate_exist_flag   (plate_exist_flag),
    .plate_valid        (plate_valid)
  );

  typedef struct {
    string name;
    int    y0, y1, x0, x1, cnt;
    bit    coinc;
    int    eu, ed, el, er, ef;
  } vec_t;

  vec_t tbl [13];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic clear_line();
    for (int i = 0; i < 1024; i++) line_bits[i] = 1'b0;
  endtask

  // One line: href high, clken per pixel (optional idle strobes with junk data)
  task automatic drive_line(input int len, input bit gaps, input bit coinc);
    per_frame_href = 1'b1;
    if (len == 0) tick();
    for (int i = 0; i < len; i++) begin
      if (gaps && ($urandom_range(0, 3) == 0)) begin
        per_frame_clken = 1'b0;
        per_frame_bit   = 1'($urandom_range(0, 1));
        tick();
      end
      per_frame_clken = 1'b1;
      per_frame_bit   = line_bits[i];
      tick();
    end
    per_frame_href  = 1'b0;
    per_frame_clken = 1'b0;
    per_frame_bit   = 1'b0;
    if (!coinc) begin
      tick();
      tick();
    end
  endtask

  // Rows 0..y1; rows y0 and y1 span x0..x1, inner rows carry cnt pixels from x0
  task automatic run_box(input int y0, input int y1, input int x0, input int x1,
                         input int cnt, input bit coinc);
    int last;
    for (int y = 0; y <= y1; y++) begin
      clear_line();
      if (y < y0) begin
        drive_line(0, 1'b0, 1'b0);
      end else begin
        last = (y == y0 || y == y1) ? x1 : x0 + cnt - 1;
        for (int i = x0; i <= last; i++) line_bits[i] = 1'b1;
        drive_line(last + 1, 1'b0, coinc && (y == y1));
      end
    end
  endtask

  // Raise vsync and check the latched box, its latency and the single-cycle pulse
  task automatic end_frame(input string name, input int eu, input int ed, input int el,
                           input int er, input int ef);
    int cyc;
    bit got;
    cyc = 0;
    got = 1'b0;
    per_frame_vsync = 1'b1;
    while (!got && cyc < 8) begin
      tick();
      cyc++;
      if (cyc == 1) per_frame_vsync = 1'b0;
      if (plate_valid) got = 1'b1;
    end
    chk({name, "_latency"}, got ? cyc : -1, 2);
    chk({name, "_up"},    int'(plate_boarder_up), eu);
    chk({name, "_down"},  int'(plate_boarder_down), ed);
    chk({name, "_left"},  int'(plate_boarder_left), el);
    chk({name, "_right"}, int'(plate_boarder_right), er);
    chk({name, "_exist"}, int'(plate_exist_flag), ef);
    tick();
    chk({name, "_pulse_end"}, int'(plate_valid), 0);
    chk({name, "_hold"}, int'(plate_boarder_down), ed);
    repeat (4) tick();
  endtask

  task automatic expect_no_valid(input string name);
    int seen;
    seen = 0;
    per_frame_vsync = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (c == 0) per_frame_vsync = 1'b0;
      if (plate_valid) seen++;
    end
    chk(name, seen, 0);
    repeat (2) tick();
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_up"},    int'(plate_boarder_up), 0);
    chk({name, "_down"},  int'(plate_boarder_down), 0);
    chk({name, "_left"},  int'(plate_boarder_left), 0);
    chk({name, "_right"}, int'(plate_boarder_right), 0);
    chk({name, "_exist"}, int'(plate_exist_flag), 0);
    chk({name, "_valid"}, int'(plate_valid), 0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int m_up, m_down, m_left, m_right, m_found, m_flag, w, h;
    int nrows, kind, s, l, len, cnt, fx, lx;

    tbl[0]  = '{"box_main",   200, 259, 100, 299, 20, 1'b0, 200, 259, 100, 299, 1};
    tbl[1]  = '{"row19",       10,  20,   5,  23, 19, 1'b0,   0,   0, 1023,  0, 0};
    tbl[2]  = '{"narrow",      50, 109,  10, 109, 20, 1'b0,  50, 109,  10, 109, 0};
    tbl[3]  = '{"min40x10",     5,  14,   0,  39, 20, 1'b0,   5,  14,   0,  39, 1};
    tbl[4]  = '{"w39",          5,  14,   0,  38, 20, 1'b0,   5,  14,   0,  38, 0};
    tbl[5]  = '{"h9",           5,  13,   0,  39, 20, 1'b0,   5,  13,   0,  39, 0};
    tbl[6]  = '{"ratio_eq",     0,  19,   0,  39, 20, 1'b0,   0,  19,   0,  39, 1};
    tbl[7]  = '{"ratio_lt",     0,  20,   0,  39, 20, 1'b0,   0,  20,   0,  39, 0};
    tbl[8]  = '{"xclip",        3,   3, 620, 659, 40, 1'b0,   3,   3, 620, 639, 0};
    tbl[9]  = '{"yclip",      480, 480,   0,  39, 40, 1'b0,   0,   0, 1023,  0, 0};
    tbl[10] = '{"coinc",        0,   9,   0,  59, 20, 1'b1,   0,   9,   0,  59, 1};
    tbl[11] = '{"pair_a",      20,  39, 200, 279, 20, 1'b0,  20,  39, 200, 279, 1};
    tbl[12] = '{"pair_b",      60,  69, 300, 349, 20, 1'b0,  60,  69, 300, 349, 1};

    rst_n           = 1'b0;
    per_frame_vsync = 1'b0;
    per_frame_href  = 1'b0;
    per_frame_clken = 1'b0;
    per_frame_bit   = 1'b0;
    repeat (3) tick();
    chk_zero("reset");
    rst_n = 1'b1;
    tick();

    // Data before the first vsync is ignored and that vsync only opens a frame
    run_box(0, 3, 0, 79, 60, 1'b0);
    expect_no_valid("first_vsync_no_valid");

    for (int t = 0; t < 13; t++) begin
      run_box(tbl[t].y0, tbl[t].y1, tbl[t].x0, tbl[t].x1, tbl[t].cnt, tbl[t].coinc);
      end_frame(tbl[t].name, tbl[t].eu, tbl[t].ed, tbl[t].el, tbl[t].er, tbl[t].ef);
    end

    // Reset at row 300 of a frame that already holds a box
    run_box(100, 109, 0, 39, 20, 1'b0);
    for (int y = 110; y < 300; y++) begin
      clear_line();
      drive_line(0, 1'b0, 1'b0);
    end
    per_frame_href = 1'b1;
    for (int i = 0; i < 10; i++) begin
      per_frame_clken = 1'b1;
      per_frame_bit   = 1'b1;
      tick();
    end
    #2 rst_n = 1'b0;
    #1;
    chk_zero("midreset");
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      per_frame_clken = 1'b1;
      per_frame_bit   = 1'b1;
      tick();
    end
    per_frame_href  = 1'b0;
    per_frame_clken = 1'b0;
    per_frame_bit   = 1'b0;
    tick();
    tick();
    chk_zero("after_reset");
    expect_no_valid("reset_vsync_no_valid");
    run_box(0, 9, 0, 59, 20, 1'b0);
    end_frame("post_reset", 0, 9, 0, 59, 1);

    // Random frames against a line-level reference model
    for (int f = 0; f < 6; f++) begin
      m_up = 0; m_down = 0; m_left = 1023; m_right = 0; m_found = 0;
      nrows = $urandom_range(5, 20);
      for (int y = 0; y < nrows; y++) begin
        clear_line();
        kind = $urandom_range(0, 3);
        len  = 0;
        if (kind != 0) begin
          s   = $urandom_range(0, 150);
          l   = $urandom_range(15, 90);
          len = s + l;
          for (int i = s; i < len; i++)
            line_bits[i] = (kind == 3) ? 1'b1 : ($urandom_range(0, 7) != 0);
        end
        cnt = 0; fx = 0; lx = 0;
        for (int i = 0; i < len; i++) begin
          if (line_bits[i] && i < 640) begin
            if (cnt == 0) fx = i;
            lx = i;
            cnt++;
          end
        end
        if (cnt >= 20 && y < 480) begin
          if (m_found == 0) m_up = y;
          m_down = y;
          if (fx < m_left) m_left = fx;
          if (lx > m_right) m_right = lx;
          m_found = 1;
        end
        drive_line(len, 1'b1, 1'b0);
      end
      w = m_right - m_left + 1;
      h = m_down - m_up + 1;
      m_flag = (m_found != 0 && w >= 40 && h >= 10 && w >= 2 * h) ? 1 : 0;
      end_frame($sformatf("rand%0d", f), m_up, m_down, m_left, m_right, m_flag);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/plate_boarder_detect.md
PLATE_BOARDER_DETECT -- requirements
Module: plate_boarder_detect

Interface
REQ-001 SHALL have parameter IMG_HDISP, default 10'd640, active pixels per line.
REQ-002 SHALL have parameter IMG_VDISP, default 10'd480, active lines per frame.
REQ-003 SHALL have parameter ROW_THRESH, default 10'd20, minimum mask pixels for a row to qualify.
REQ-004 SHALL have parameter MIN_W, default 10'd40, minimum accepted box width.
REQ-005 SHALL have parameter MIN_H, default 10'd10, minimum accepted box height.
REQ-006 SHALL have ports: clk  input  1  system clock.
REQ-007 SHALL have ports: rst_n  input  1  asynchronous active-low reset.
REQ-008 per_frame_vsync  input  1  frame sync, rising edge marks frame start.
REQ-009 per_frame_href  input  1  line valid.
REQ-010 per_frame_clken  input  1  pixel strobe.
REQ-011 per_frame_bit  input  1  binarized plate-colour mask, 1 = candidate pixel.
REQ-012 plate_boarder_up / plate_boarder_down  output  10 each  first / last qualifying row.
REQ-013 plate_boarder_left / plate_boarder_right  output  10 each  min first-x / max last-x over qualifying rows.
REQ-014 plate_exist_flag  output  1  last latched box passed size checks.
REQ-015 plate_valid  output  1  one-cycle pulse when the four boundaries and the flag update.

Function
REQ-016 SHALL register vsync and href once; vsync_rise = vsync & ~vsync_r; href_fall = ~href & href_r.
REQ-017 SHALL count x on each clken with href high, clear x on href_fall, increment y on href_fall, clear both on vsync_rise.
REQ-018 Per row, SHALL track mask count (saturating at 1023), first x with bit=1, last x with bit=1.
REQ-019 On href_fall, SHALL commit the row: if count >= ROW_THRESH, set up to y (first commit only), set down to y, left = min(left, first x), right = max(right, last x), set found.
REQ-020 Row counters SHALL clear on the cycle after commit.
REQ-021 FSM states: WAIT_FRAME (after reset, ignore data until first vsync_rise), ACTIVE (accumulate), LATCH (one cycle).
REQ-022 Transitions: WAIT_FRAME -> ACTIVE on vsync_rise; ACTIVE -> LATCH on vsync_rise; LATCH -> ACTIVE unconditionally.
REQ-023 A row commit and vsync_rise in the same cycle: the commit SHALL be included in the frame being latched.
REQ-024 In LATCH, SHALL copy accumulators to the outputs and set plate_exist_flag = found && (right-left+1 >= MIN_W) && (down-up+1 >= MIN_H) && (right-left+1 >= 2*(down-up+1)).
REQ-025 Width/height arithmetic SHALL use 11 bits to avoid wrap.
REQ-026 plate_valid SHALL be high exactly in the cycle after LATCH; outputs SHALL change only then.
REQ-027 Latency: outputs SHALL update 2 cycles after vsync_rise.
REQ-028 Accumulators SHALL be reset in LATCH (left=1023, right=0, up=0, down=0, found=0).
REQ-029 clken/href activity during LATCH SHALL be ignored; upstream guarantees ≥4 cycles from vsync_rise to first href.
REQ-030 If found=0, SHALL still latch: boundaries = accumulator reset values, flag = 0.
REQ-031 Outputs SHALL hold between updates, for direct use by the box-overlay stage of the next frame.
REQ-032 x beyond IMG_HDISP-1 or y beyond IMG_VDISP-1 SHALL not commit.

Reset
REQ-033 On rst_n low, SHALL force all outputs to 0, FSM to WAIT_FRAME, clear all counters, accumulators, and sync registers, asynchronously.
REQ-034 Reset mid-frame SHALL discard the partial frame; first output after reset only follows a full frame.

Structure
REQ-035 IMG_HDISP/IMG_VDISP defaults SHALL come from the shared image parameter header used by the other image-process blocks; the FSM state encodings are local.
REQ-036 One sub-module, plate_row_stat, SHALL hold the per-row count/first/last logic; the top holds x/y counters, frame accumulators, and the FSM.

Verification
REQ-037 Frame with mask=1 at x 100..299, rows 200..259 -> next update up=200 down=259 left=100 right=299 exist=1 valid pulse 1 cycle.
REQ-038 Rows with 19 mask pixels only (ROW_THRESH=20) -> exist=0, no row qualifies.
REQ-039 Box 100x60 (width < 2*height) -> exist=0, boundaries still reported.
REQ-040 Last row's href_fall coincident with vsync_rise -> down includes that row.
REQ-041 rst_n pulsed at row 300 of a frame -> outputs 0; no valid until one full frame after next vsync_rise.
REQ-042 Two frames with different boxes back-to-back -> second valid carries only second-frame values (no min/max carryover).
